fifo_burst_reader: RTL and testbench

Read side of the 12-bit SDR sample FIFO, running in the tx clock domain. It waits until the FIFO holds enough samples, then drains it in fixed-length bursts onto a valid/ready sample stream with start/end-of-frame markers. It accounts for the FIFO's one-cycle read latency and absorbs downstream backpressure in a 2-entry output buffer. On FIFO underflow mid-burst it inserts zero samples, so frame length is always exact.

---
 rtl/fifo_burst_reader.sv | 123 ++++++++++++
 tb/tb_fifo_burst_reader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Read side of the SDR sample FIFO: waits for START_LEVEL samples, then drains
// fixed-length frames onto a valid/ready stream, padding zeros on underflow.
module fifo_burst_reader #(
  parameter int DATA_W      = 12,
  parameter int BURST_LEN   = 16,
  parameter int START_LEVEL = 8,
  parameter int LVL_W       = 11
) (
  input  logic              tx_clk_i,
  input  logic              rst_i,
  input  logic [LVL_W-1:0]  fifo_level_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  input  logic [DATA_W-1:0] fifo_rd_data_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              tx_sof_o,
  output logic              tx_eof_o,
  output logic              underflow_o,
  output logic              busy_o,
  output logic [15:0]       burst_cnt_o,
  output logic [15:0]       pad_cnt_o
);

  localparam int IDX_W = $clog2(BURST_LEN + 1);
  localparam logic [IDX_W-1:0] BL_C     = IDX_W'(BURST_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);
  localparam logic [LVL_W-1:0] START_C  = LVL_W'(START_LEVEL);

  // S_IDLE: waiting for the FIFO level; S_BURST: issuing reads/pads for one frame
  typedef enum logic {S_IDLE, S_BURST} state_t;
  state_t r_state, w_state_nxt;

  logic [IDX_W-1:0]  r_issued;
  logic              r_inflight, r_inf_sof, r_inf_eof;
  logic [DATA_W-1:0] r_buf_data [2];
  logic [1:0]        r_buf_sof, r_buf_eof;
  logic              r_wr_ptr, r_rd_ptr;
  logic [1:0]        r_buf_cnt;

  logic              w_pop, w_space_ok, w_can_issue, w_rd, w_pad, w_issue;
  logic              w_sof, w_eof, w_push, w_push_sof, w_push_eof;
  logic [DATA_W-1:0] w_push_data;
  logic [2:0]        w_used, w_limit;

  // Credit counts the in-flight read so its data always has a slot waiting.
  assign w_pop       = tx_valid_o & tx_ready_i;
  assign w_used      = {1'b0, r_buf_cnt} + {2'b0, r_inflight};
  assign w_limit     = 3'd2 + {2'b0, w_pop};
  assign w_space_ok  = w_used < w_limit;
  assign w_can_issue = (r_state == S_BURST) && (r_issued < BL_C) && w_space_ok;
  assign w_rd        = w_can_issue & ~fifo_empty_i;
  assign w_pad       = w_can_issue & fifo_empty_i & ~r_inflight;
  assign w_issue     = w_rd | w_pad;
  assign w_sof       = (r_issued == '0);
  assign w_eof       = (r_issued == LAST_IDX);

  // Pads require no read in flight, so the two push sources never collide.
  assign w_push      = r_inflight | w_pad;
  assign w_push_data = r_inflight ? fifo_rd_data_i : '0;
  assign w_push_sof  = r_inflight ? r_inf_sof : w_sof;
  assign w_push_eof  = r_inflight ? r_inf_eof : w_eof;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (fifo_level_i >= START_C) w_state_nxt = S_BURST;
      S_BURST: if (w_issue && (r_issued == LAST_IDX)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_issued    <= '0;
      r_inflight  <= 1'b0;
      r_inf_sof   <= 1'b0;
      r_inf_eof   <= 1'b0;
      for (int i = 0; i < 2; i++) r_buf_data[i] <= '0;
      r_buf_sof   <= '0;
      r_buf_eof   <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_buf_cnt   <= '0;
      burst_cnt_o <= '0;
      pad_cnt_o   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE)
        r_issued <= '0;
      else if (w_issue)
        r_issued <= r_issued + IDX_W'(1);
      r_inflight <= w_rd;
      r_inf_sof  <= w_sof;
      r_inf_eof  <= w_eof;
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= w_push_data;
        r_buf_sof[r_wr_ptr]  <= w_push_sof;
        r_buf_eof[r_wr_ptr]  <= w_push_eof;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_buf_cnt <= r_buf_cnt + {1'b0, w_push} - {1'b0, w_pop};
      if (w_pop && tx_eof_o) burst_cnt_o <= burst_cnt_o + 16'd1;
      if (w_pad && (pad_cnt_o != 16'hFFFF)) pad_cnt_o <= pad_cnt_o + 16'd1;
    end
  end

  always_ff @(posedge tx_clk_i) begin
    if (!rst_i) assert (!(w_push && !w_pop && (r_buf_cnt == 2'd2)));
  end

  assign tx_valid_o   = (r_buf_cnt != 2'd0);
  assign tx_data_o    = tx_valid_o ? r_buf_data[r_rd_ptr] : '0;
  assign tx_sof_o     = tx_valid_o & r_buf_sof[r_rd_ptr];
  assign tx_eof_o     = tx_valid_o & r_buf_eof[r_rd_ptr];
  assign fifo_rd_en_o = w_rd;
  assign underflow_o  = w_pad;
  assign busy_o       = (r_state == S_BURST);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model with one-cycle read latency and a
// scoreboard of expected {data,sof,eof} compared against stream handshakes.
module tb_fifo_burst_reader;

  localparam int DATA_W = 12;
  localparam int LVL_W  = 11;
  localparam int BL     = 16;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              s;
    logic              e;
  } smp_t;

  logic              tx_clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [LVL_W-1:0]  fifo_level_i = '0;
  logic              fifo_empty_i = 1'b1;
  logic              fifo_rd_en_o;
  logic [DATA_W-1:0] fifo_rd_data_i = '0;
  logic [DATA_W-1:0] tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i = 1'b0;
  logic              tx_sof_o, tx_eof_o, underflow_o, busy_o;
  logic [15:0]       burst_cnt_o, pad_cnt_o;

  fifo_burst_reader dut (
    .tx_clk_i(tx_clk_i), .rst_i(rst_i), .fifo_level_i(fifo_level_i),
    .fifo_empty_i(fifo_empty_i), .fifo_rd_en_o(fifo_rd_en_o),
    .fifo_rd_data_i(fifo_rd_data_i), .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_sof_o(tx_sof_o),
    .tx_eof_o(tx_eof_o), .underflow_o(underflow_o), .busy_o(busy_o),
    .burst_cnt_o(burst_cnt_o), .pad_cnt_o(pad_cnt_o)
  );

  always #5 tx_clk_i = ~tx_clk_i;

  int checks = 0, failures = 0;
  logic [DATA_W-1:0] fifo_q[$];
  smp_t exp_q[$], obs_q[$];
  int exp_idx = 0;
  int iss_cnt, pop_cnt, rd_prev, max_outst;
  int space_viol, stall_viol, zero_viol, rd_empty_viol, uf_seen;
  logic prev_stall = 1'b0;
  smp_t prev_s;
  logic rand_ready = 1'b0;

  task automatic update_flags();
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_level_i = LVL_W'(fifo_q.size());
  endtask

  task automatic clear_model();
    fifo_q.delete(); exp_q.delete(); obs_q.delete();
    exp_idx = 0; iss_cnt = 0; pop_cnt = 0; rd_prev = 0; max_outst = 0;
    space_viol = 0; stall_viol = 0; zero_viol = 0; rd_empty_viol = 0; uf_seen = 0;
    prev_stall = 1'b0;
    update_flags();
  endtask

  // One clock: sample at negedge, then update FIFO model/inputs #1 after posedge.
  task automatic tick();
    int buf_n, space, hs;
    logic rd_pend;
    @(negedge tx_clk_i);
    hs = (tx_valid_o && tx_ready_i) ? 1 : 0;
    buf_n = iss_cnt - rd_prev - pop_cnt;
    space = 2 - buf_n - rd_prev + hs;
    if (fifo_rd_en_o && space <= 0) space_viol++;
    if (buf_n + rd_prev > max_outst) max_outst = buf_n + rd_prev;
    if (!tx_valid_o && tx_data_o !== '0) zero_viol++;
    if (prev_stall && (!tx_valid_o || tx_data_o !== prev_s.d ||
        tx_sof_o !== prev_s.s || tx_eof_o !== prev_s.e)) stall_viol++;
    prev_stall = tx_valid_o && !tx_ready_i;
    prev_s = '{d: tx_data_o, s: tx_sof_o, e: tx_eof_o};
    if (hs == 1) begin
      obs_q.push_back('{d: tx_data_o, s: tx_sof_o, e: tx_eof_o});
      pop_cnt++;
    end
    if (underflow_o) uf_seen++;
    iss_cnt += (fifo_rd_en_o ? 1 : 0) + (underflow_o ? 1 : 0);
    rd_prev = fifo_rd_en_o ? 1 : 0;
    rd_pend = fifo_rd_en_o;
    @(posedge tx_clk_i); #1;
    if (rd_pend) begin
      if (fifo_q.size() > 0) fifo_rd_data_i = fifo_q.pop_front();
      else begin rd_empty_viol++; fifo_rd_data_i = 12'h5A5; end
    end
    update_flags();
    if (rand_ready) tx_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic apply_reset(int n);
    rst_i = 1'b1;
    repeat (n) tick();
    rst_i = 1'b0;
    clear_model();
  endtask

  // Pushes samples into the FIFO model and their expected frame slots.
  task automatic load(int n, int base, int abc);
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] pat [4];
    pat[0] = 12'hABC; pat[1] = 12'hFFF; pat[2] = 12'hDDD; pat[3] = 12'hCCC;
    for (int i = 0; i < n; i++) begin
      v = (abc != 0) ? pat[i % 4] : DATA_W'(base + i);
      fifo_q.push_back(v);
      exp_q.push_back('{d: v, s: (exp_idx == 0), e: (exp_idx == BL - 1)});
      exp_idx = (exp_idx + 1) % BL;
    end
    update_flags();
  endtask

  task automatic expect_pads(int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{d: '0, s: (exp_idx == 0), e: (exp_idx == BL - 1)});
      exp_idx = (exp_idx + 1) % BL;
    end
  endtask

  task automatic run_until(int n, int budget);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin tick(); k++; end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; tx_ready_i = 1'b0; fifo_q.delete(); update_flags();
    repeat (10) tick();
    checks++;
    if ({fifo_rd_en_o, tx_valid_o, tx_sof_o, tx_eof_o, underflow_o, busy_o} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000000",
               {fifo_rd_en_o, tx_valid_o, tx_sof_o, tx_eof_o, underflow_o, busy_o});
    end
    checks++;
    if (tx_data_o !== '0) begin failures++; $display("FAIL reset_data: got %h expected 000", tx_data_o); end
    checks++;
    if ({burst_cnt_o, pad_cnt_o} !== 32'h0) begin
      failures++; $display("FAIL reset_counters: got %h/%h expected 0/0", burst_cnt_o, pad_cnt_o);
    end
    rst_i = 1'b0;
    clear_model();
  endtask

  task automatic test_level_start();
    smp_t o, e;
    tx_ready_i = 1'b1;
    load(7, 'h100, 0);
    repeat (5) begin
      tick();
      checks++;
      if (fifo_rd_en_o !== 1'b0 || busy_o !== 1'b0) begin
        failures++; $display("FAIL level7_idle: got rd=%b busy=%b expected 0 0", fifo_rd_en_o, busy_o);
      end
    end
    load(1, 'h107, 0);
    tick();
    checks++;
    if (busy_o !== 1'b1 || fifo_rd_en_o !== 1'b1 || tx_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL start_n1: got busy=%b rd=%b valid=%b expected 1 1 0", busy_o, fifo_rd_en_o, tx_valid_o);
    end
    tick();
    checks++;
    if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL start_n2: got valid=%b expected 0", tx_valid_o); end
    tick();
    checks++;
    if (tx_valid_o !== 1'b1 || tx_sof_o !== 1'b1 || tx_data_o !== 12'h100) begin
      failures++;
      $display("FAIL start_n3: got valid=%b sof=%b data=%h expected 1 1 100", tx_valid_o, tx_sof_o, tx_data_o);
    end
    run_until(BL, 100);
    checks++;
    if (obs_q.size() != BL) begin failures++; $display("FAIL burst1_count: got %0d expected %0d", obs_q.size(), BL); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL burst1_sample: got %h/%b/%b expected %h/%b/%b", o.d, o.s, o.e, e.d, e.s, e.e); end
    end
    checks++;
    if (burst_cnt_o !== 16'd1) begin failures++; $display("FAIL burst1_cnt: got %0d expected 1", burst_cnt_o); end
  endtask

  task automatic test_continuous();
    smp_t o, e;
    int gaps = 0, k = 0;
    logic started = 1'b0;
    apply_reset(3);
    tx_ready_i = 1'b1;
    load(1040, 0, 1);
    while (obs_q.size() < 1040 && k < 3000) begin
      if (tx_valid_o) started = 1'b1;
      else if (started) gaps++;
      tick(); k++;
    end
    checks++;
    if (obs_q.size() != 1040) begin failures++; $display("FAIL cont_count: got %0d expected 1040", obs_q.size()); end
    checks++;
    if (gaps != 64) begin failures++; $display("FAIL cont_gaps: got %0d expected 64", gaps); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL cont_sample: got %h/%b/%b expected %h/%b/%b", o.d, o.s, o.e, e.d, e.s, e.e); end
    end
    checks++;
    if (burst_cnt_o !== 16'd65) begin failures++; $display("FAIL cont_bursts: got %0d expected 65", burst_cnt_o); end
    checks++;
    if (pad_cnt_o !== 16'd0 || uf_seen != 0) begin failures++; $display("FAIL cont_pads: got %0d/%0d expected 0/0", pad_cnt_o, uf_seen); end
  endtask

  task automatic test_backpressure();
    smp_t o, e;
    logic [15:0] bc0;
    bc0 = burst_cnt_o;
    space_viol = 0; stall_viol = 0; zero_viol = 0; rd_empty_viol = 0;
    rand_ready = 1'b1;
    load(48, 'h200, 0);
    run_until(48, 2000);
    rand_ready = 1'b0; tx_ready_i = 1'b1;
    checks++;
    if (obs_q.size() != 48) begin failures++; $display("FAIL bp_count: got %0d expected 48", obs_q.size()); end
    checks++;
    if (stall_viol != 0) begin failures++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_viol); end
    checks++;
    if (space_viol != 0) begin failures++; $display("FAIL bp_credit: got %0d reads without space expected 0", space_viol); end
    checks++;
    if (zero_viol != 0 || rd_empty_viol != 0) begin
      failures++; $display("FAIL bp_misc: got zero=%0d rd_empty=%0d expected 0 0", zero_viol, rd_empty_viol);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL bp_sample: got %h/%b/%b expected %h/%b/%b", o.d, o.s, o.e, e.d, e.s, e.e); end
    end
    checks++;
    if (burst_cnt_o !== bc0 + 16'd3) begin failures++; $display("FAIL bp_bursts: got %0d expected %0d", burst_cnt_o, bc0 + 16'd3); end
  endtask

  task automatic test_underflow();
    smp_t o, e;
    apply_reset(2);
    tx_ready_i = 1'b1;
    load(8, 'h300, 0);
    expect_pads(8);
    run_until(BL, 200);
    checks++;
    if (obs_q.size() != BL) begin failures++; $display("FAIL uf_count: got %0d expected %0d", obs_q.size(), BL); end
    checks++;
    if (uf_seen != 8) begin failures++; $display("FAIL uf_pulses: got %0d expected 8", uf_seen); end
    checks++;
    if (pad_cnt_o !== 16'd8) begin failures++; $display("FAIL uf_padcnt: got %0d expected 8", pad_cnt_o); end
    checks++;
    if (rd_empty_viol != 0) begin failures++; $display("FAIL uf_rd_empty: got %0d expected 0", rd_empty_viol); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL uf_sample: got %h/%b/%b expected %h/%b/%b", o.d, o.s, o.e, e.d, e.s, e.e); end
    end
    checks++;
    if (burst_cnt_o !== 16'd1) begin failures++; $display("FAIL uf_bursts: got %0d expected 1", burst_cnt_o); end
  endtask

  task automatic test_back_to_back();
    smp_t o, e;
    logic [15:0] bc0;
    int k = 0;
    bc0 = burst_cnt_o;
    max_outst = 0; space_viol = 0;
    tx_ready_i = 1'b1;
    load(32, 'h400, 0);
    while (!(tx_valid_o && tx_eof_o) && k < 100) begin tick(); k++; end
    checks++;
    if (!(tx_valid_o && tx_eof_o)) begin failures++; $display("FAIL b2b_eof_wait: got no eof expected eof within 100 cycles"); end
    tx_ready_i = 1'b0;
    repeat (5) tick();
    tx_ready_i = 1'b1;
    run_until(32, 300);
    checks++;
    if (obs_q.size() != 32) begin failures++; $display("FAIL b2b_count: got %0d expected 32", obs_q.size()); end
    checks++;
    if (max_outst > 3 || space_viol != 0) begin
      failures++; $display("FAIL b2b_occupancy: got max=%0d viol=%0d expected <=3 0", max_outst, space_viol);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL b2b_sample: got %h/%b/%b expected %h/%b/%b", o.d, o.s, o.e, e.d, e.s, e.e); end
    end
    checks++;
    if (burst_cnt_o !== bc0 + 16'd2) begin failures++; $display("FAIL b2b_bursts: got %0d expected %0d", burst_cnt_o, bc0 + 16'd2); end
  endtask

  task automatic test_reset_midburst();
    int k = 0;
    tx_ready_i = 1'b1;
    load(20, 'h500, 0);
    while (!tx_valid_o && k < 20) begin tick(); k++; end
    tick(); tick();
    checks++;
    if (busy_o !== 1'b1 || tx_valid_o !== 1'b1) begin
      failures++; $display("FAIL mid_precond: got busy=%b valid=%b expected 1 1", busy_o, tx_valid_o);
    end
    rst_i = 1'b1;
    tick();
    checks++;
    if (tx_valid_o !== 1'b0 || fifo_rd_en_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got valid=%b rd=%b busy=%b expected 0 0 0", tx_valid_o, fifo_rd_en_o, busy_o);
    end
    checks++;
    if (burst_cnt_o !== 16'd0 || pad_cnt_o !== 16'd0) begin
      failures++; $display("FAIL mid_counters: got %0d/%0d expected 0/0", burst_cnt_o, pad_cnt_o);
    end
    rst_i = 1'b0;
    clear_model();
  endtask

  initial begin
    clear_model();
    test_reset();
    test_level_start();
    test_continuous();
    test_backpressure();
    test_underflow();
    test_back_to_back();
    test_reset_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
